// File: rtl/race_pkg.sv
// rtl/race_pkg.sv - shared state encoding, key codes and helpers for the race sequencer
package race_pkg;

  localparam int POS_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_RACE  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] KEY_NONE = 4'b0000;
  localparam logic [3:0] ARROW_UP = 4'b0001;

  // Frame timer that sticks at all-ones instead of wrapping back to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/zone_hit.sv
// rtl/zone_hit.sv - inclusive rectangular zone test on an unsigned x/y position
module zone_hit
  import race_pkg::*;
#(
  parameter logic [POS_W-1:0] X0 = '0,
  parameter logic [POS_W-1:0] X1 = '0,
  parameter logic [POS_W-1:0] Y0 = '0,
  parameter logic [POS_W-1:0] Y1 = '0
) (
  input  logic [POS_W-1:0] x,
  input  logic [POS_W-1:0] y,
  output logic             hit
);

  // Offset-from-lower-bound form: (v - lo) wraps large when v < lo, so a single
  // unsigned compare against the span covers both bounds (assumes lo <= hi).
  localparam logic [POS_W-1:0] X_SPAN = X1 - X0;
  localparam logic [POS_W-1:0] Y_SPAN = Y1 - Y0;

  logic [POS_W-1:0] x_off;
  logic [POS_W-1:0] y_off;

  // Combinational box membership.
  always_comb begin
    x_off = x - X0;
    y_off = y - Y0;
    hit   = (x_off <= X_SPAN) && (y_off <= Y_SPAN);
  end

endmodule

// File: rtl/race_ctl.sv
// rtl/race_ctl.sv - race sequencer: start key, 3-2-1 countdown, lap counting and race timing
module race_ctl
  import race_pkg::*;
#(
  parameter int               FRAMES_PER_SEC = 60,
  parameter int               LAPS           = 3,
  parameter logic [3:0]       KEY_START      = ARROW_UP,
  parameter logic [POS_W-1:0] CP_X0          = 11'd400,
  parameter logic [POS_W-1:0] CP_X1          = 11'd420,
  parameter logic [POS_W-1:0] CP_Y0          = 11'd0,
  parameter logic [POS_W-1:0] CP_Y1          = 11'd150,
  parameter logic [POS_W-1:0] FL_X0          = 11'd100,
  parameter logic [POS_W-1:0] FL_X1          = 11'd120,
  parameter logic [POS_W-1:0] FL_Y0          = 11'd0,
  parameter logic [POS_W-1:0] FL_Y1          = 11'd150
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             vsync_tick,
  input  logic [3:0]       key,
  input  logic [POS_W-1:0] xpos,
  input  logic [POS_W-1:0] ypos,
  output logic             car_rst,
  output logic             car_en,
  output logic [1:0]       state,
  output logic [1:0]       countdown,
  output logic [3:0]       lap,
  output logic [15:0]      race_time,
  output logic             finished
);

  localparam int               CNT_W      = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAMES_PER_SEC - 1);
  localparam logic [3:0]       LAPS_W     = 4'(LAPS);

  state_t           st;
  logic [CNT_W-1:0] frame_cnt;
  logic             cp_seen;
  logic             released;
  logic             cp_hit;
  logic             fl_hit;
  logic             start;
  logic [3:0]       lap_inc;

  zone_hit #(.X0(CP_X0), .X1(CP_X1), .Y0(CP_Y0), .Y1(CP_Y1)) u_cp_zone (
    .x   (xpos),
    .y   (ypos),
    .hit (cp_hit)
  );

  zone_hit #(.X0(FL_X0), .X1(FL_X1), .Y0(FL_Y0), .Y1(FL_Y1)) u_fl_zone (
    .x   (xpos),
    .y   (ypos),
    .hit (fl_hit)
  );

  // Start key is honoured in IDLE, and in DONE only after the key has been let go once.
  always_comb begin
    start   = (key == KEY_START) && ((st == ST_IDLE) || ((st == ST_DONE) && released));
    lap_inc = lap + 4'd1;
  end

  // Race FSM with countdown, lap and timer registers; all outputs come straight from flops.
  always_ff @(posedge pclk) begin
    if (rst) begin
      st        <= ST_IDLE;
      car_rst   <= 1'b1;
      car_en    <= 1'b0;
      countdown <= 2'd0;
      lap       <= 4'd0;
      race_time <= 16'd0;
      finished  <= 1'b0;
      frame_cnt <= '0;
      cp_seen   <= 1'b0;
      released  <= 1'b0;
    end else if (start) begin
      st        <= ST_COUNT;
      car_rst   <= 1'b1;
      car_en    <= 1'b0;
      countdown <= 2'd3;
      lap       <= 4'd0;
      race_time <= 16'd0;
      finished  <= 1'b0;
      frame_cnt <= '0;
      cp_seen   <= 1'b0;
      released  <= 1'b0;
    end else begin
      car_en <= 1'b0;
      case (st)
        ST_IDLE: begin
          car_rst   <= 1'b1;
          finished  <= 1'b0;
          countdown <= 2'd0;
        end
        ST_COUNT: begin
          car_rst <= 1'b1;
          if (vsync_tick) begin
            if (frame_cnt == FRAME_LAST) begin
              frame_cnt <= '0;
              if (countdown == 2'd1) begin
                st        <= ST_RACE;
                countdown <= 2'd0;
                car_rst   <= 1'b0;
              end else begin
                countdown <= countdown - 2'd1;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        ST_RACE: begin
          car_rst <= 1'b0;
          car_en  <= vsync_tick;
          if (vsync_tick) begin
            race_time <= sat_inc16(race_time);
            // Finish only counts after the checkpoint; uses the pre-tick flag.
            if (fl_hit && cp_seen) begin
              lap     <= lap_inc;
              cp_seen <= 1'b0;
              if (lap_inc == LAPS_W) begin
                st       <= ST_DONE;
                finished <= 1'b1;
              end
            end
            // Later assignment wins, so an overlapping checkpoint re-arms the flag.
            if (cp_hit) begin
              cp_seen <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          car_rst  <= 1'b0;
          finished <= 1'b1;
          if (key == KEY_NONE) begin
            released <= 1'b1;
          end
        end
        default: begin
          st        <= ST_IDLE;
          car_rst   <= 1'b1;
          finished  <= 1'b0;
          countdown <= 2'd0;
        end
      endcase
    end
  end

  assign state = st;

endmodule

// File: doc/race_ctl.md
Name: race_ctl

Overview:
- Race sequencer for the car datapath.
- Holds the car in reset until the start key is pressed, then runs a 3-2-1 countdown.
- During the race it issues one car-update enable per video frame, counts laps through checkpoint/finish zones and times the race in frames.
- Sits between the keyboard decoder / vsync tick generator and car_ctl; its status outputs feed the HUD renderer.

Parameters:
- FRAMES_PER_SEC, 60, vsync ticks per countdown step
- LAPS, 3, laps required to finish (1..15)
- KEY_START, 4'b0001, key code that starts or restarts a race
- CP_X0, CP_X1, CP_Y0, CP_Y1, 400/420/0/150, checkpoint zone bounds, inclusive, 11-bit
- FL_X0, FL_X1, FL_Y0, FL_Y1, 100/120/0/150, finish-line zone bounds, inclusive, 11-bit

Ports:
- pclk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- vsync_tick  in  1  one-pclk pulse per frame
- key  in  4  decoded key code; 0 = none pressed
- xpos  in  11  car x position from car_ctl
- ypos  in  11  car y position from car_ctl
- car_rst  out  1  holds car_ctl in reset
- car_en  out  1  one-pclk update strobe to car_ctl
- state  out  2  IDLE=0, COUNT=1, RACE=2, DONE=3
- countdown  out  2  remaining countdown digit, 3..1; 0 outside COUNT
- lap  out  4  completed laps
- race_time  out  16  race duration in frames, saturating
- finished  out  1  high in DONE

Behaviour:
- Reset, synchronous, active-high, clock pclk. Every output registered. Reset values:
  - state=IDLE, car_rst=1, car_en=0, countdown=0, lap=0, race_time=0, finished=0
  - internal frame counter=0, cp_seen=0, released=0
  - Reset mid-race aborts immediately to these values.
- IDLE:
  - car_rst=1.
  - key==KEY_START -> COUNT next cycle, with countdown=3, frame counter=0, lap=0, race_time=0, cp_seen=0.
- COUNT:
  - car_rst=1.
  - Each vsync_tick increments the frame counter.
  - When the counter reaches FRAMES_PER_SEC-1 on a tick: counter clears and countdown decrements.
  - Decrement from 1 -> RACE, countdown=0, car_rst=0 in the same edge.
  - Total COUNT duration: exactly 3*FRAMES_PER_SEC ticks.
  - Key input is ignored in COUNT.
- RACE:
  - car_rst=0.
  - car_en is a registered copy of vsync_tick: asserted one pclk after each tick, 1 cycle wide.
  - Each tick: race_time increments, saturating at 16'hFFFF, no wrap.
  - Zone tests use the xpos/ypos values sampled on the tick cycle only. Bounds are inclusive, unsigned 11-bit compares.
  - In checkpoint zone -> cp_seen=1.
  - In finish zone with cp_seen==1 (value before this tick) -> lap+1, cp_seen=0.
  - Finish without cp_seen does not count, which prevents re-crossing and reversing exploits.
  - Overlapping zones: the finish rule uses the old cp_seen, then cp_seen is set, if the checkpoint test is also true.
  - When lap becomes LAPS -> DONE on the same edge. The race_time increment of that tick is kept.
- DONE:
  - car_en=0, car_rst=0 (car frozen, position held), finished=1.
  - lap and race_time are held.
  - key==0 sets released.
  - released && key==KEY_START -> COUNT, initialised as from IDLE, released cleared.
  - A key still held from the race does not restart it.
- State value 2'bxx unreachable. Any illegal encoding -> IDLE.

Decomposition:
- race_pkg holds:
  - state encoding localparams (ST_IDLE, ST_COUNT, ST_RACE, ST_DONE)
  - key code constants (KEY_NONE, ARROW_UP = 4'b0001)
  - shared 11-bit position width POS_W
- Sub-module zone_hit: parameterised inclusive box comparator on x/y, combinational, 1-bit hit. Instantiated twice (checkpoint, finish).
- FSM, counters and lap logic stay in race_ctl.

Test Plan:
- Reset, then key=0 for 100 ticks -> state=0, car_rst=1, car_en never asserted, all counters 0.
- key=4'b0001 one cycle (FRAMES_PER_SEC=4 override) -> countdown 3,2,1 each 4 ticks; state=2 and car_rst=0 after tick 12; first car_en 1 pclk after tick 13.
- In RACE, drive positions finish zone -> checkpoint (410,50) -> finish (110,50), three times -> lap 0,1,2,3; DONE on the third finish; finished=1; car_en stops.
- Finish crossed twice without checkpoint -> lap stays 0; point inside both zones (overlap override) on one tick -> cp_seen set, no lap.
- Hold race for 70000 ticks -> race_time sticks at 16'hFFFF.
- In DONE with key held at 4'b0001 -> stays DONE; key=0 then 4'b0001 -> COUNT with lap=0, race_time=0. Assert rst mid-RACE -> all outputs at reset values next cycle.
